ahb_sram_ws: RTL and testbench
==============================

Name: ahb_sram_ws

Overview:
- AHB-Lite SRAM slave, next generation of the team's single-cycle SRAM slave.
- Adds parametrised data width and depth, hsize-driven byte lanes, programmable wait states, two-cycle ERROR response, and write-to-read forwarding.
- Sits behind the interconnect decoder as a memory region; one transfer outstanding at a time, fully AHB-pipelined.

Parameters:
- HADDR_WIDTH, 32, address bus width (10..64).
- DATA_WIDTH, 32, data bus width (32, 64, 128).
- MEM_DEPTH, 1024, words of DATA_WIDTH bits; power of two.
- WAIT_STATES, 0, extra data-phase cycles with hreadyout low (0..7).

Ports:
- hclk  in  1  system clock
- hreset  in  1  reset; one clock; reset is asynchronous and active-high
- hsel  in  1  slave select from decoder
- haddr  in  HADDR_WIDTH  byte address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1 = write
- hsize  in  3  transfer size, log2 bytes
- hburst  in  3  burst type; accepted, not used
- hwdata  in  DATA_WIDTH  write data, valid in the data phase
- hready  in  1  bus ready from interconnect
- hrdata  out  DATA_WIDTH  read data
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Accept: acc = hsel & hready & htrans[1]. On acc, register addr, hwrite, hsize and lane mask; the data phase starts next cycle.
- Word index: haddr[log2(MEM_DEPTH)+OFS-1 : OFS], where OFS = log2(DATA_WIDTH/8).
- Error conditions:
  - hsize > OFS.
  - haddr not aligned to the size.
  - haddr >= MEM_DEPTH*DATA_WIDTH/8, i.e. any upper address bit set.
- Lane mask: 2^hsize consecutive bytes starting at haddr[OFS-1:0], little-endian.
- IDLE/BUSY or unselected transfers: no data phase; hreadyout=1, hresp=0.
- States:
  - IDLE: acc & !err -> WAIT if WAIT_STATES>0, else DATA. acc & err -> ERR1.
  - WAIT: hreadyout=0; a counter loads WAIT_STATES-1 and decrements; at 0 -> DATA.
  - DATA: hreadyout=1, hresp=0; on the same edge, acc -> next transfer per the IDLE rules, else IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1; acc -> next per the IDLE rules, else IDLE.
- Write commit: masked bytes of hwdata are written at the edge ending DATA. Unmasked bytes are unchanged. ERROR transfers never modify memory.
- Read:
  - The array is read synchronously; the word is captured into hrdata at the edge entering DATA (the accept edge when WAIT_STATES=0, the last WAIT edge otherwise).
  - hrdata is valid throughout DATA and holds its value otherwise.
  - Full word is returned on all byte lanes.
- Forwarding: if a read's capture edge coincides with a write commit to the same word, hrdata = stored word with the write's masked bytes replaced by the new hwdata bytes. No stale data.
- hreadyout is low only in WAIT and ERR1.
- Reset values: state IDLE, hreadyout=1, hresp=0, hrdata=0, counter=0.
- Memory contents are not reset and are undefined after power-up.
- Reset mid-transfer: the transfer is abandoned and no write occurs. Outputs return to reset values asynchronously.
- Back-to-back transfers sustain one per cycle when WAIT_STATES=0.

Test Plan:
- DATA_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF word @0x10, then read @0x10 in the next address phase -> hrdata=0xDEADBEEF via forwarding; hreadyout stays 1.
- Byte write: hsize=0 @0x13, hwdata=0xAA000000 over stored 0x11223344 -> read returns 0xAA223344; halfword @0x12, hwdata 0x55660000 -> 0x55663344.
- WAIT_STATES=3: single read -> hreadyout low for exactly 3 cycles, high on the 4th cycle with valid hrdata; a write is committed only on the final edge.
- Errors: read @ MEM_DEPTH*4 -> ERR1 (hresp=1, hreadyout=0) then ERR2 (hresp=1, hreadyout=1); hsize=2 @0x2 -> ERROR, memory unchanged.
- Reset: assert hreset during WAIT of a write to @0x20 -> hreadyout=1, hresp=0, hrdata=0 immediately; later read @0x20 returns the prior value.
- Pipelining: NONSEQ/SEQ 4-beat INCR write then 4-beat read, with an IDLE and a BUSY inserted -> 8 data phases, no spurious writes, correct data.

Source files
------------

// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave with hsize byte lanes, programmable wait states,
// two-cycle ERROR response and write-to-read forwarding.
module ahb_sram_ws #(
    parameter int unsigned HADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic                   hsel,
    input  logic [HADDR_WIDTH-1:0] haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [2:0]             hburst,
    input  logic [DATA_WIDTH-1:0]  hwdata,
    input  logic                   hready,
    output logic [DATA_WIDTH-1:0]  hrdata,
    output logic                   hreadyout,
    output logic                   hresp
);

    localparam int unsigned NB       = DATA_WIDTH / 8;
    localparam int unsigned OFS      = $clog2(NB);
    localparam int unsigned AW       = $clog2(MEM_DEPTH);
    localparam int unsigned TOP      = AW + OFS;
    localparam bit          HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [2:0]  CNT_INIT = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_t;

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic            write_q;
    logic [NB-1:0]   mask_q;

    logic            acc;
    logic            start;
    logic            size_err;
    logic            align_err;
    logic            range_err;
    logic            err;
    logic [OFS-1:0]  off;
    logic [NB-1:0]   lane;
    state_t          start_st;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  we;
    logic                  capture;
    logic                  fwd;
    logic [AW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic unused;
    assign unused = ^{hburst, htrans[0]};

    assign acc   = hsel & hready & htrans[1];
    assign start = acc & (state_q inside {StIdle, StData, StErr2});
    assign off   = haddr[OFS-1:0];

    assign size_err = int'(hsize) > int'(OFS);

    if (HADDR_WIDTH > TOP) begin : g_range
        assign range_err = |haddr[HADDR_WIDTH-1:TOP];
    end else begin : g_no_range
        assign range_err = 1'b0;
    end

    always_comb begin
        align_err = 1'b0;
        for (int i = 0; i < int'(OFS); i++) begin
            if ((i < int'(hsize)) && haddr[i]) align_err = 1'b1;
        end
    end

    // 2^hsize consecutive byte lanes starting at the byte offset
    always_comb begin
        lane = '0;
        for (int b = 0; b < int'(NB); b++) begin
            lane[b] = (b >= int'(off)) && (b < int'(off) + (1 << hsize));
        end
    end

    assign err      = size_err | align_err | range_err;
    assign start_st = err ? StErr1 : (HAS_WAIT ? StWait : StData);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            mask_q    <= '0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
        end else begin
            if (start) begin
                idx_q   <= haddr[TOP-1:OFS];
                write_q <= hwrite;
                mask_q  <= lane;
            end
            unique case (state_q)
                StIdle, StData, StErr2: begin
                    if (start) begin
                        state_q   <= start_st;
                        cnt_q     <= CNT_INIT;
                        hreadyout <= !(err || HAS_WAIT);
                        hresp     <= err;
                    end else begin
                        state_q   <= StIdle;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        state_q   <= StData;
                        hreadyout <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StErr1: begin
                    state_q   <= StErr2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    state_q   <= StIdle;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                end
            endcase
        end
    end

    // Commit happens on the edge that ends the DATA cycle; reset forces IDLE so
    // an interrupted write never reaches the array.
    assign we = (state_q == StData) & write_q;

    always_ff @(posedge hclk) begin
        if (we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (mask_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign rd_idx  = (state_q == StWait) ? idx_q : haddr[TOP-1:OFS];
    assign capture = (start && !err && !hwrite && !HAS_WAIT) ||
                     ((state_q == StWait) && (cnt_q == 3'd0) && !write_q);
    assign fwd     = we && (idx_q == rd_idx);

    always_comb begin
        rd_word = mem[rd_idx];
        for (int b = 0; b < int'(NB); b++) begin
            if (fwd && mask_q[b]) rd_word[8*b +: 8] = hwdata[8*b +: 8];
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hrdata <= '0;
        end else if (capture) begin
            hrdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Scoreboard bench: one slave with no wait states, one with three.
module tb_ahb_sram_ws;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BZ = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic             hreset;
    logic [1:0]       hsel;
    logic [1:0][31:0] haddr;
    logic [1:0][1:0]  htrans;
    logic [1:0]       hwrite;
    logic [1:0][2:0]  hsize;
    logic [1:0][2:0]  hburst;
    logic [1:0][31:0] hwdata;

    logic [31:0] hrdata0, hrdata1;
    logic        rdy0, rdy1, resp0, resp1;
    logic [1:0]       rdy;
    logic [1:0]       resp;
    logic [1:0][31:0] rdata;
    assign rdy      = {rdy1, rdy0};
    assign resp     = {resp1, resp0};
    assign rdata[0] = hrdata0;
    assign rdata[1] = hrdata1;

    ahb_sram_ws #(.HADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
        .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hwdata(hwdata[0]),
        .hready(rdy0), .hrdata(hrdata0), .hreadyout(rdy0), .hresp(resp0)
    );

    ahb_sram_ws #(.HADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
        .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hwdata(hwdata[1]),
        .hready(rdy1), .hrdata(hrdata1), .hreadyout(rdy1), .hresp(resp1)
    );

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] data;
        int          id;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec = 0;
    int n_bad = 0;
    int vec_id = 0;
    logic [1:0][31:0] pend;
    bit [1:0] in_dp;
    int wcnt [2];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endfunction

    task automatic wait_accept(input int d);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge hclk);
            if (rdy[d]) ok = 1'b1;
            @(posedge hclk);
            #1;
            if (ok) break;
        end
        check($sformatf("d%0d accept", d), 32'(ok), 32'd1);
    endtask

    // Drive one address phase (plus the previous transfer's write data) and
    // hold it until the slave accepts.
    task automatic issue(input int d, input logic [1:0] tr, input logic [31:0] a,
                         input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        hsel[d]   = 1'b1;
        haddr[d]  = a;
        htrans[d] = tr;
        hwrite[d] = wr;
        hsize[d]  = sz;
        hburst[d] = 3'd1;
        hwdata[d] = pend[d];
        pend[d]   = tr[1] ? wd : 32'h0;
        if (tr[1]) begin
            e.rd   = !wr;
            e.err  = exp_err;
            e.data = exp_rd;
            e.id   = vec_id++;
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        wait_accept(d);
    endtask

    task automatic mon(input int d);
        exp_t e;
        bit   have;
        if (hreset) begin
            in_dp[d] = 1'b0;
            if (d == 0) q0.delete();
            else q1.delete();
            return;
        end
        if (in_dp[d]) begin
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                check($sformatf("d%0d data phase without expectation", d), 32'd1, 32'd0);
                in_dp[d] = 1'b0;
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                if (!rdy[d]) begin
                    wcnt[d]++;
                    if (e.err) check($sformatf("d%0d v%0d err1 hresp", d, e.id), 32'(resp[d]), 32'd1);
                end else begin
                    if (d == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                    check($sformatf("d%0d v%0d hresp", d, e.id), 32'(resp[d]), 32'(e.err));
                    if (e.rd && !e.err)
                        check($sformatf("d%0d v%0d hrdata", d, e.id), rdata[d], e.data);
                    check($sformatf("d%0d v%0d wait cycles", d, e.id), 32'(wcnt[d]),
                          e.err ? 32'd1 : ((d == 0) ? 32'd0 : 32'd3));
                    in_dp[d] = 1'b0;
                end
            end
        end else begin
            check($sformatf("d%0d idle ready/resp", d), {30'd0, rdy[d], resp[d]}, 32'd2);
        end
        if (rdy[d] && hsel[d] && htrans[d][1]) begin
            in_dp[d] = 1'b1;
            wcnt[d]  = 0;
        end
    endtask

    always @(negedge hclk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        hreset = 1'b1;
        hsel   = '0;
        haddr  = '0;
        htrans = '0;
        hwrite = '0;
        hsize  = '0;
        hburst = '0;
        hwdata = '0;
        pend   = '0;
        in_dp  = '0;
        wcnt[0] = 0;
        wcnt[1] = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset hreadyout", d), 32'(rdy[d]), 32'd1);
            check($sformatf("d%0d reset hresp", d), 32'(resp[d]), 32'd0);
            check($sformatf("d%0d reset hrdata", d), rdata[d], 32'd0);
        end
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;

        // No wait states: forwarding, byte lanes, errors
        issue(0, NS, 32'h10, 1, 3'd2, 32'hDEADBEEF, 32'h0, 0);
        issue(0, NS, 32'h10, 0, 3'd2, 32'h0, 32'hDEADBEEF, 0);
        issue(0, NS, 32'h10, 1, 3'd2, 32'h11223344, 32'h0, 0);
        issue(0, NS, 32'h13, 1, 3'd0, 32'hAA000000, 32'h0, 0);
        issue(0, NS, 32'h10, 0, 3'd2, 32'h0, 32'hAA223344, 0);
        issue(0, NS, 32'h12, 1, 3'd1, 32'h55660000, 32'h0, 0);
        issue(0, NS, 32'h10, 0, 3'd2, 32'h0, 32'h55663344, 0);
        issue(0, NS, 32'h11, 0, 3'd0, 32'h0, 32'h55663344, 0);
        issue(0, NS, 32'h00, 1, 3'd2, 32'h01020304, 32'h0, 0);
        issue(0, NS, 32'h1000, 0, 3'd2, 32'h0, 32'h0, 1);
        issue(0, NS, 32'h02, 1, 3'd2, 32'hFFFFFFFF, 32'h0, 1);
        issue(0, NS, 32'h00, 1, 3'd3, 32'hFFFFFFFF, 32'h0, 1);
        issue(0, NS, 32'h00, 0, 3'd2, 32'h0, 32'h01020304, 0);
        issue(0, NS, 32'h50, 1, 3'd2, 32'h5A5A5A5A, 32'h0, 0);
        // INCR4 write then read with BUSY/IDLE slots
        issue(0, NS, 32'h40, 1, 3'd2, 32'hCAFE0000, 32'h0, 0);
        issue(0, SQ, 32'h44, 1, 3'd2, 32'hCAFE0001, 32'h0, 0);
        issue(0, BZ, 32'h50, 1, 3'd2, 32'h0, 32'h0, 0);
        issue(0, SQ, 32'h48, 1, 3'd2, 32'hCAFE0002, 32'h0, 0);
        issue(0, SQ, 32'h4C, 1, 3'd2, 32'hCAFE0003, 32'h0, 0);
        issue(0, ID, 32'h54, 1, 3'd2, 32'h0, 32'h0, 0);
        issue(0, NS, 32'h40, 0, 3'd2, 32'h0, 32'hCAFE0000, 0);
        issue(0, SQ, 32'h44, 0, 3'd2, 32'h0, 32'hCAFE0001, 0);
        issue(0, BZ, 32'h50, 0, 3'd2, 32'h0, 32'h0, 0);
        issue(0, SQ, 32'h48, 0, 3'd2, 32'h0, 32'hCAFE0002, 0);
        issue(0, SQ, 32'h4C, 0, 3'd2, 32'h0, 32'hCAFE0003, 0);
        issue(0, ID, 32'h54, 1, 3'd2, 32'h0, 32'h0, 0);
        issue(0, NS, 32'h50, 0, 3'd2, 32'h0, 32'h5A5A5A5A, 0);
        issue(0, ID, 32'h0, 0, 3'd2, 32'h0, 32'h0, 0);
        hsel[0] = 1'b0;

        // Three wait states
        issue(1, NS, 32'h20, 1, 3'd2, 32'h12345678, 32'h0, 0);
        issue(1, NS, 32'h20, 0, 3'd2, 32'h0, 32'h12345678, 0);
        issue(1, ID, 32'h0, 0, 3'd2, 32'h0, 32'h0, 0);
        issue(1, ID, 32'h0, 0, 3'd2, 32'h0, 32'h0, 0);
        issue(1, ID, 32'h0, 0, 3'd2, 32'h0, 32'h0, 0);
        issue(1, ID, 32'h0, 0, 3'd2, 32'h0, 32'h0, 0);
        // Reset lands in the WAIT of a write; it must be abandoned
        issue(1, NS, 32'h20, 1, 3'd2, 32'hBAD0BAD0, 32'h0, 0);
        hsel[1]   = 1'b0;
        htrans[1] = ID;
        hwdata[1] = pend[1];
        pend[1]   = 32'h0;
        #2 hreset = 1'b1;
        #1;
        check("d1 mid-wait reset hreadyout", 32'(rdy[1]), 32'd1);
        check("d1 mid-wait reset hresp", 32'(resp[1]), 32'd0);
        check("d1 mid-wait reset hrdata", rdata[1], 32'd0);
        @(negedge hclk);
        @(posedge hclk);
        #1 hreset = 1'b0;
        issue(1, NS, 32'h20, 0, 3'd2, 32'h0, 32'h12345678, 0);
        issue(1, NS, 32'h1000, 0, 3'd2, 32'h0, 32'h0, 1);
        issue(1, NS, 32'h24, 1, 3'd2, 32'h00000000, 32'h0, 0);
        issue(1, NS, 32'h26, 1, 3'd1, 32'hBEEF0000, 32'h0, 0);
        issue(1, NS, 32'h24, 0, 3'd2, 32'h0, 32'hBEEF0000, 0);
        issue(1, NS, 32'h25, 1, 3'd0, 32'h0000CD00, 32'h0, 0);
        issue(1, NS, 32'h24, 0, 3'd2, 32'h0, 32'hBEEFCD00, 0);
        issue(1, ID, 32'h0, 0, 3'd2, 32'h0, 32'h0, 0);
        hsel[1] = 1'b0;

        repeat (8) @(posedge hclk);
        #1;
        check("d0 scoreboard drained", 32'(q0.size()), 32'd0);
        check("d1 scoreboard drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
